// File: rtl/dac1411_pkg.sv
// Shared definitions for the AD9717 (Zmod DAC1411) transmitter: FSM states,
// SPI word geometry and the register init table sent after power-up.
package dac1411_pkg;

   typedef enum logic [2:0] {
      WAIT_PWR,
      SPI_LOAD,
      SPI_SHIFT,
      SPI_GAP,
      RUN
   } state_e;

   localparam int SPI_WORD_W = 16;
   localparam int INIT_LEN   = 4;
   localparam int IDX_W      = $clog2(INIT_LEN);

   // Write-command word: R/W=0, N=00 (single byte), 5-bit address, 8-bit data.
   function automatic logic [SPI_WORD_W-1:0] spi_write(input logic [4:0] addr,
                                                        input logic [7:0] data);
      return {1'b0, 2'b00, addr, data};
   endfunction

   localparam logic [SPI_WORD_W-1:0] INIT_TABLE [INIT_LEN] = '{
      spi_write(5'h00, 8'h00),   // release soft reset
      spi_write(5'h02, 8'h80),   // two's-complement input data
      spi_write(5'h03, 8'h00),   // I full-scale gain default
      spi_write(5'h06, 8'h00)    // Q full-scale gain default
   };

endpackage

// File: rtl/dac1411_spi_tx.sv
// Mode-0 SPI write engine: latches one word on load, shifts it MSB first with
// a divided SCLK, and flags the cycle of the final falling edge on done_o.
module dac1411_spi_tx
   import dac1411_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic [SPI_WORD_W-1:0] word_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  sclk_o,
   output logic                  cs_o,
   output logic                  sdio_o
);

   localparam int BIT_W = $clog2(SPI_WORD_W);

   logic [SPI_WORD_W-1:0] shreg_q, shreg_d;
   logic [7:0]            div_q, div_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic                  busy_q, busy_d;
   logic                  sclk_q, sclk_d;
   logic                  cs_q, cs_d;
   logic                  sdio_q, sdio_d;
   logic                  half_end;

   assign half_end = busy_q && (div_q == 8'(CLK_DIV - 1));
   assign done_o   = half_end && sclk_q && (bit_q == BIT_W'(SPI_WORD_W - 1));

   always_comb begin
      // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
      shreg_d = shreg_q;
      div_d   = div_q;
      bit_d   = bit_q;
      busy_d  = busy_q;
      sclk_d  = sclk_q;
      cs_d    = cs_q;
      sdio_d  = sdio_q;
      if (load_i && !busy_q) begin
         shreg_d = word_i;
         sdio_d  = word_i[SPI_WORD_W-1];
         cs_d    = 1'b0;
         sclk_d  = 1'b0;
         div_d   = '0;
         bit_d   = '0;
         busy_d  = 1'b1;
      end else if (busy_q) begin
         div_d = half_end ? 8'd0 : div_q + 8'd1;
         if (half_end) begin
            if (!sclk_q) begin
               sclk_d = 1'b1;
            end else begin
               // Falling edge: data moves only here, keeping it stable across the rising edge.
               sclk_d = 1'b0;
               if (bit_q == BIT_W'(SPI_WORD_W - 1)) begin
                  busy_d = 1'b0;
                  cs_d   = 1'b1;
                  sdio_d = 1'b0;
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
                  shreg_d = {shreg_q[SPI_WORD_W-2:0], 1'b0};
                  sdio_d  = shreg_q[SPI_WORD_W-2];
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shreg_q <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         busy_q  <= 1'b0;
         sclk_q  <= 1'b0;
         cs_q    <= 1'b1;
         sdio_q  <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         busy_q  <= busy_d;
         sclk_q  <= sclk_d;
         cs_q    <= cs_d;
         sdio_q  <= sdio_d;
      end
   end

   assign busy_o = busy_q;
   assign sclk_o = sclk_q;
   assign cs_o   = cs_q;
   assign sdio_o = sdio_q;

endmodule

// File: rtl/dac1411_tx.sv
// Zmod DAC1411 front end: waits for power-up, programs the AD9717 over SPI,
// then interleaves ch1/ch2 sample pairs onto the shared DAC bus.
module dac1411_tx
   import dac1411_pkg::*;
#(
   parameter int ZMOD_DATA_SIZE = 14,
   parameter int SPI_CLK_DIV    = 4,
   parameter int POWERUP_CYCLES = 1000
) (
   input  logic                      i_sys_clock,
   input  logic                      i_reset,
   input  logic [ZMOD_DATA_SIZE-1:0] i_ch1_data,
   input  logic [ZMOD_DATA_SIZE-1:0] i_ch2_data,
   input  logic                      i_valid,
   output logic                      o_ready,
   output logic [ZMOD_DATA_SIZE-1:0] o_dac_data,
   output logic                      o_dac_dclkio,
   output logic                      o_dac_sclk,
   output logic                      o_dac_cs,
   output logic                      o_dac_sdio,
   output logic                      o_dac_ch1_scale,
   output logic                      o_dac_ch2_scale,
   output logic                      o_dac_en,
   output logic                      o_dac_init_done
);

   localparam int PW = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;

   state_e                    state_q;
   logic [PW-1:0]             pwr_cnt_q;
   logic [8:0]                gap_cnt_q;
   logic [IDX_W-1:0]          idx_q;
   logic                      phase_q;
   logic                      en_q;
   logic                      init_done_q;
   logic [ZMOD_DATA_SIZE-1:0] ch1_q, ch2_q, dac_q;

   logic spi_load, spi_busy, spi_done;

   // The cs-high window includes the SPI_LOAD cycle, hence 2*DIV-1 cycles in SPI_GAP.
   assign spi_load = (state_q == SPI_LOAD) && !spi_busy;

   dac1411_spi_tx #(
      .CLK_DIV(SPI_CLK_DIV)
   ) u_spi (
      .clk_i (i_sys_clock),
      .rst_i (i_reset),
      .load_i(spi_load),
      .word_i(INIT_TABLE[idx_q]),
      .busy_o(spi_busy),
      .done_o(spi_done),
      .sclk_o(o_dac_sclk),
      .cs_o  (o_dac_cs),
      .sdio_o(o_dac_sdio)
   );

   always_ff @(posedge i_sys_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= WAIT_PWR;
         pwr_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         idx_q       <= '0;
         phase_q     <= 1'b0;
         en_q        <= 1'b0;
         init_done_q <= 1'b0;
         ch1_q       <= '0;
         ch2_q       <= '0;
         dac_q       <= '0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values of the others.
         case (state_q)
            WAIT_PWR: begin
               if (pwr_cnt_q == PW'(POWERUP_CYCLES - 1)) begin
                  pwr_cnt_q <= '0;
                  state_q   <= SPI_LOAD;
               end else begin
                  pwr_cnt_q <= pwr_cnt_q + PW'(1);
               end
            end
            SPI_LOAD: begin
               if (spi_load) state_q <= SPI_SHIFT;
            end
            SPI_SHIFT: begin
               if (spi_done) begin
                  gap_cnt_q <= '0;
                  state_q   <= SPI_GAP;
               end
            end
            SPI_GAP: begin
               if (gap_cnt_q == 9'(2 * SPI_CLK_DIV - 2)) begin
                  gap_cnt_q <= '0;
                  if (idx_q == IDX_W'(INIT_LEN - 1)) begin
                     state_q     <= RUN;
                     en_q        <= 1'b1;
                     init_done_q <= 1'b1;
                  end else begin
                     idx_q   <= idx_q + IDX_W'(1);
                     state_q <= SPI_LOAD;
                  end
               end else begin
                  gap_cnt_q <= gap_cnt_q + 9'd1;
               end
            end
            RUN: begin
               phase_q <= ~phase_q;
               if (phase_q) begin
                  // Pair boundary: take a new pair if offered, else replay the held one.
                  if (i_valid) begin
                     ch1_q <= i_ch1_data;
                     ch2_q <= i_ch2_data;
                     dac_q <= i_ch1_data;
                  end else begin
                     dac_q <= ch1_q;
                  end
               end else begin
                  dac_q <= ch2_q;
               end
            end
            default: state_q <= WAIT_PWR;
         endcase
      end
   end

   assign o_ready         = (state_q == RUN) && phase_q;
   assign o_dac_data      = dac_q;
   assign o_dac_dclkio    = phase_q;
   assign o_dac_en        = en_q;
   assign o_dac_init_done = init_done_q;
   assign o_dac_ch1_scale = 1'b0;
   assign o_dac_ch2_scale = 1'b0;

endmodule
